// File: rtl/rv_stream_fifo.sv
// First-word-fall-through ready/valid stream buffer with occupancy, almost-full
// and per-side handshake strobes for the systolic-MAC datapath.
module rv_stream_fifo #(
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 4,
  parameter int AFULL_TH = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_W-1:0]          s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_W-1:0]          m_data,
  output logic                       en_data_Rx,
  output logic                       en_data_Tx,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);
  localparam logic [PW-1:0] PTR_ZERO   = PW'(0);
  localparam logic [PW-1:0] AFULL_TH_W = PW'(AFULL_TH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     count_q, count_d;
  logic              empty_s, full_s, push_s, pop_s;

  // Pointer MSB is the wrap bit: equal indices with differing wrap bits means full.
  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign s_ready     = !full_s && !reset && !flush;
  assign m_valid     = !empty_s && !reset && !flush;
  assign push_s      = s_valid && s_ready;
  assign pop_s       = m_valid && m_ready;
  assign en_data_Rx  = push_s;
  assign en_data_Tx  = pop_s;
  assign m_data      = m_valid ? mem_q[rd_ptr_q[AW-1:0]] : {DATA_W{1'b0}};
  assign count       = reset ? PTR_ZERO : count_q;
  assign almost_full = !reset && (count_q >= AFULL_TH_W);

  // Next-state for pointers and occupancy; flush empties the buffer.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = PTR_ZERO;
      rd_ptr_d = PTR_ZERO;
      count_d  = PTR_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + PTR_ONE;
        2'b01:   count_d = count_q - PTR_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= PTR_ZERO;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; flush leaves contents in place, only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= s_data;
    end
  end

endmodule

// File: tb/tb_rv_stream_fifo.sv
// Self-checking bench for rv_stream_fifo: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_rv_stream_fifo;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 4;
  localparam int AFULL  = DEPTH - 1;

  logic              clk = 1'b0;
  logic              reset, flush, s_valid, m_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_ready, m_valid, en_data_Rx, en_data_Tx, almost_full;
  logic [DATA_W-1:0] m_data;
  logic [2:0]        count;

  int n_tests = 0;
  int n_fail  = 0;

  rv_stream_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(AFULL)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .en_data_Rx(en_data_Rx), .en_data_Tx(en_data_Tx),
    .count(count), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  // Reference model: contents as a plain queue.
  logic [DATA_W-1:0] mq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset || flush) begin
      mq.delete();
    end else begin
      automatic bit rx = s_valid && (mq.size() < DEPTH);
      automatic bit tx = m_ready && (mq.size() > 0);
      if (tx) void'(mq.pop_front());
      if (rx) mq.push_back(s_data);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    automatic bit            e_sr = !reset && !flush && (mq.size() < DEPTH);
    automatic bit            e_mv = !reset && !flush && (mq.size() > 0);
    automatic logic [63:0]   e_md = e_mv ? mq[0] : 64'd0;
    automatic int            e_ct = reset ? 0 : mq.size();
    chk("m_s_ready", {63'd0, s_ready}, {63'd0, e_sr});
    chk("m_m_valid", {63'd0, m_valid}, {63'd0, e_mv});
    chk("m_m_data", m_data, e_md);
    chk("m_count", {61'd0, count}, 64'(e_ct));
    chk("m_afull", {63'd0, almost_full}, {63'd0, (!reset && e_ct >= AFULL)});
    chk("m_rx", {63'd0, en_data_Rx}, {63'd0, (s_valid && e_sr)});
    chk("m_tx", {63'd0, en_data_Tx}, {63'd0, (m_ready && e_mv)});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [DATA_W-1:0] got[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int next_in;
    int cyc;
    reset = 1'b1; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = 64'd0;
    step(); step();
    #2;
    chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
    chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("rst_count", {61'd0, count}, 64'd0);
    reset = 1'b0;
    #2;
    chk("post_rst_s_ready", {63'd0, s_ready}, 64'd1);
    step();

    // Basic transfer
    s_valid = 1'b1; s_data = 64'hDEADBEEFCAFEBABE;
    #2 chk("basic_rx", {63'd0, en_data_Rx}, 64'd1);
    step();
    s_valid = 1'b0;
    #2;
    chk("basic_mv", {63'd0, m_valid}, 64'd1);
    chk("basic_md", m_data, 64'hDEADBEEFCAFEBABE);
    chk("basic_cnt", {61'd0, count}, 64'd1);
    m_ready = 1'b1;
    #2 chk("basic_tx", {63'd0, en_data_Tx}, 64'd1);
    step();
    m_ready = 1'b0;
    #2;
    chk("basic_mv_after", {63'd0, m_valid}, 64'd0);
    chk("basic_cnt_after", {61'd0, count}, 64'd0);

    // Fill to full
    for (int i = 1; i <= 4; i++) begin
      s_valid = 1'b1; s_data = 64'(i);
      #2;
      chk("fill_rx", {63'd0, en_data_Rx}, 64'd1);
      chk("fill_afull", {63'd0, almost_full}, (i == 4) ? 64'd1 : 64'd0);
      step();
    end
    s_data = 64'd5;
    #2;
    chk("full_s_ready", {63'd0, s_ready}, 64'd0);
    chk("full_count", {61'd0, count}, 64'd4);
    chk("full_rx", {63'd0, en_data_Rx}, 64'd0);

    // Full with simultaneous pop: no bypass
    m_ready = 1'b1;
    #2;
    chk("fullpop_tx", {63'd0, en_data_Tx}, 64'd1);
    chk("fullpop_rx", {63'd0, en_data_Rx}, 64'd0);
    chk("fullpop_md", m_data, 64'd1);
    step();
    m_ready = 1'b0; s_valid = 1'b0;
    #2;
    chk("fullpop_count", {61'd0, count}, 64'd3);
    chk("fullpop_s_ready", {63'd0, s_ready}, 64'd1);
    chk("fullpop_md_next", m_data, 64'd2);

    // Flush with a concurrent push at count=3
    flush = 1'b1; s_valid = 1'b1; s_data = 64'hAA;
    #2 chk("flush_rx", {63'd0, en_data_Rx}, 64'd0);
    step();
    flush = 1'b0; s_valid = 1'b0;
    #2;
    chk("flush_count", {61'd0, count}, 64'd0);
    chk("flush_mv", {63'd0, m_valid}, 64'd0);
    chk("flush_md", m_data, 64'd0);

    // Reset mid-stream at count=3
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = 64'(10 + i);
      step();
    end
    reset = 1'b1; s_valid = 1'b1; s_data = 64'hBB;
    #2;
    chk("rst_mid_s_ready", {63'd0, s_ready}, 64'd0);
    chk("rst_mid_rx", {63'd0, en_data_Rx}, 64'd0);
    step();
    reset = 1'b0; s_valid = 1'b0;
    #2;
    chk("rst_mid_count", {61'd0, count}, 64'd0);
    chk("rst_mid_mv", {63'd0, m_valid}, 64'd0);
    chk("rst_mid_md", m_data, 64'd0);

    // Wrap-around ordering with random stalls
    next_in = 0;
    cyc = 0;
    while (got.size() < 20 && cyc < 400) begin
      s_valid = (next_in < 20) && ($urandom_range(0, 2) != 0);
      s_data  = 64'(next_in);
      m_ready = ($urandom_range(0, 1) != 0);
      #2;
      if (m_valid && m_ready) got.push_back(m_data);
      if (s_valid && s_ready) next_in++;
      step();
      cyc++;
    end
    s_valid = 1'b0; m_ready = 1'b0;
    chk("wrap_count_words", 64'(got.size()), 64'd20);
    for (int i = 0; i < got.size(); i++) begin
      chk("wrap_order", got[i], 64'(i));
    end

    // Back-to-back throughput from empty
    s_valid = 1'b1; m_ready = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      s_data = 64'(100 + c);
      #2;
      chk("b2b_tx", {63'd0, en_data_Tx}, (c >= 2) ? 64'd1 : 64'd0);
      chk("b2b_count", {61'd0, count}, (c >= 2) ? 64'd1 : 64'd0);
      step();
    end
    s_valid = 1'b0;
    step();
    m_ready = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
